// File: rtl/uart_rx_oversample_if.sv
// Receive-side byte stream of the oversampling UART receiver: a
// valid/ready byte channel plus the two one-cycle error pulses.
interface uart_rx_oversample_if;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady;
  logic       FramingError;
  logic       Overrun;

  // Receiver side: produces bytes and error pulses.
  modport master (
    output DataOut,
    output DataOutValid,
    output FramingError,
    output Overrun,
    input  DataOutReady
  );

  // Consumer side: accepts bytes and observes error pulses.
  modport slave (
    input  DataOut,
    input  DataOutValid,
    input  FramingError,
    input  Overrun,
    output DataOutReady
  );
endinterface

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver (8N1, LSB first).
// The serial line is synchronised, then sampled Oversample times per bit.
// Each bit is decided by a 3-sample majority around the middle of the bit.
// Received bytes go into a one-entry output buffer with a valid/ready handshake.
module uart_rx_oversample #(
  parameter int ClockFreq  = 100_000_000,
  parameter int BaudRate   = 115_200,
  parameter int Oversample = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  SIn,
  uart_rx_oversample_if.master  rx
);

  localparam int TickTime = ClockFreq / (BaudRate * Oversample);
  localparam int TickW    = (TickTime > 1) ? $clog2(TickTime) : 1;
  localparam int SubW     = (Oversample > 1) ? $clog2(Oversample) : 1;

  localparam logic [TickW-1:0] TickLast = TickW'(TickTime - 1);
  localparam logic [SubW-1:0]  SubLast  = SubW'(Oversample - 1);
  localparam logic [SubW-1:0]  SubA     = SubW'(Oversample / 2 - 1);
  localparam logic [SubW-1:0]  SubB     = SubW'(Oversample / 2);
  localparam logic [SubW-1:0]  SubC     = SubW'(Oversample / 2 + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Synchroniser stages and the previous synchronised value for edge detection.
  logic [1:0]       sync_q;
  logic             prev_q;

  state_t           state_q, state_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SubW-1:0]  sub_q, sub_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       samp_q, samp_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             fe_q, fe_d;
  logic             ovr_q, ovr_d;

  logic rx_s;
  logic fall;
  logic tick;
  logic mid;
  logic bit_end;
  logic maj;
  logic good;
  logic bad;

  assign rx_s = sync_q[1];
  assign fall = prev_q & ~rx_s;
  assign tick = (tick_cnt_q == TickLast);
  assign mid  = tick && (sub_q == SubC);
  assign bit_end = tick && (sub_q == SubLast);
  // The two earlier mid-bit samples are stored; the third is the live sample.
  assign maj  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  assign rx.DataOut      = data_q;
  assign rx.DataOutValid = valid_q;
  assign rx.FramingError = fe_q;
  assign rx.Overrun      = ovr_q;

  // Two-flop synchroniser plus edge-detect history; the idle line is high.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], SIn};
      prev_q <= sync_q[1];
    end
  end

  // Frame state, counters, sample history and output buffer registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      sub_q      <= '0;
      bit_q      <= 3'd0;
      samp_q     <= 2'b00;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      sub_q      <= sub_d;
      bit_q      <= bit_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end

  // Next-state logic: bit timing, majority sampling, frame decode.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    sub_d      = sub_q;
    bit_d      = bit_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    good       = 1'b0;
    bad        = 1'b0;

    // Counters only run while a frame is in progress; IDLE holds them at 0.
    if (state_q != IDLE) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      if (tick) begin
        sub_d = (sub_q == SubLast) ? '0 : sub_q + 1'b1;
        if (sub_q == SubA) samp_d[0] = rx_s;
        if (sub_q == SubB) samp_d[1] = rx_s;
      end
    end

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d    = START;
          tick_cnt_d = '0;
          sub_d      = '0;
        end
      end
      START: begin
        if (mid && maj) begin
          // Glitch rather than a real start bit: drop silently.
          state_d    = IDLE;
          tick_cnt_d = '0;
          sub_d      = '0;
        end else if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (mid) shift_d = {maj, shift_q[7:1]};
        if (bit_end) begin
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        // Decide at mid stop bit and return to IDLE at once so a
        // back-to-back start edge is not missed.
        if (mid) begin
          state_d    = IDLE;
          tick_cnt_d = '0;
          sub_d      = '0;
          if (maj) good = 1'b1;
          else     bad  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output buffer: load, consume or drop, and the one-cycle error pulses.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = bad;
    ovr_d   = 1'b0;

    if (valid_q && rx.DataOutReady) valid_d = 1'b0;

    if (good) begin
      if (!valid_q || rx.DataOutReady) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: directed frames plus random traffic.
// Expected events are queued at stimulus time; a negedge monitor matches
// DUT events (new byte, framing error, overrun) against the queue.
module tb_uart_rx_oversample;

  localparam int BitCycles = 160;

  logic clk = 1'b0;
  logic rst;
  logic sin;

  uart_rx_oversample_if bus ();

  uart_rx_oversample #(
    .ClockFreq  (1_600_000),
    .BaudRate   (10_000),
    .Oversample (16)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .SIn   (sin),
    .rx    (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] kind;  // 0 byte, 1 framing error, 2 overrun
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: does the output buffer hold an unconsumed byte?
  bit buf_full;

  int dir_total = 0;
  int dir_pass  = 0;
  int mon_total = 0;
  int mon_pass  = 0;

  task automatic dcheck(input string name, input int act, input int expv);
    dir_total++;
    if (act == expv) dir_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  task automatic mcheck(input string name, input int act, input int expv);
    mon_total++;
    if (act == expv) mon_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) step();
  endtask

  // Model: decides what the receiver must report for one whole frame.
  task automatic expect_frame(input logic [7:0] b, input logic stopb, input bit rdy);
    exp_t e;
    if (rdy) buf_full = 1'b0;
    if (!stopb) begin
      e.kind = 2'd1; e.val = 8'h00;
    end else if (buf_full) begin
      e.kind = 2'd2; e.val = 8'h00;
    end else begin
      e.kind = 2'd0; e.val = b;
      buf_full = !rdy;
    end
    exp_q.push_back(e);
    $display("frame 0x%02h stop=%0b ready=%0b -> expect kind %0d", b, stopb, rdy, e.kind);
  endtask

  // Drives one 10-bit frame; optionally inverts one sample period of one bit.
  task automatic send_frame(input logic [7:0] b, input logic stopb, input bit rdy,
                            input int glitch_bit);
    logic [9:0] bits;
    bits = {stopb, b, 1'b0};
    expect_frame(b, stopb, rdy);
    bus.DataOutReady = rdy;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < BitCycles; c++) begin
        sin = bits[i] ^ ((i == glitch_bit) && (c >= 85) && (c < 95));
        step();
      end
    end
    sin = 1'b1;
    bus.DataOutReady = 1'b0;
  endtask

  task automatic drain();
    bus.DataOutReady = 1'b1;
    step();
    bus.DataOutReady = 1'b0;
    buf_full = 1'b0;
  endtask

  // Monitor: matches every DUT event against the expectation queue.
  logic       pv, pr, pfe, povr;
  logic [7:0] pd;
  initial begin
    pv = 1'b0; pr = 1'b0; pfe = 1'b0; povr = 1'b0; pd = 8'h00;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pv = 1'b0; pr = 1'b0; pfe = 1'b0; povr = 1'b0;
    end else begin
      if (bus.FramingError || bus.Overrun)
        mcheck("fe_ovr_exclusive", int'(bus.FramingError & bus.Overrun), 0);
      if (pv && !pr) begin
        mcheck("valid_held", int'(bus.DataOutValid), 1);
        mcheck("data_stable", int'(bus.DataOut), int'(pd));
      end
      if (bus.FramingError) begin
        mcheck("fe_single_cycle", int'(pfe), 0);
        if (exp_q.size() == 0) mcheck("unexpected_fe", 1, 0);
        else begin
          e = exp_q.pop_front();
          mcheck("event_kind_fe", int'(e.kind), 1);
        end
      end
      if (bus.Overrun) begin
        mcheck("ovr_single_cycle", int'(povr), 0);
        if (exp_q.size() == 0) mcheck("unexpected_ovr", 1, 0);
        else begin
          e = exp_q.pop_front();
          mcheck("event_kind_ovr", int'(e.kind), 2);
        end
      end
      if (bus.DataOutValid && (!pv || pr)) begin
        if (exp_q.size() == 0) mcheck("unexpected_byte", 1, 0);
        else begin
          e = exp_q.pop_front();
          mcheck("event_kind_byte", int'(e.kind), 0);
          mcheck("byte_value", int'(bus.DataOut), int'(e.val));
        end
      end
      pv   = bus.DataOutValid;
      pr   = bus.DataOutReady;
      pd   = bus.DataOut;
      pfe  = bus.FramingError;
      povr = bus.Overrun;
    end
  end

  initial begin
    logic [9:0] ff_bits;
    logic [7:0] rb;
    logic       rs;
    bit         rr;

    rst = 1'b1;
    sin = 1'b1;
    bus.DataOutReady = 1'b0;
    buf_full = 1'b0;
    repeat (4) step();
    dcheck("reset_dataout", int'(bus.DataOut), 0);
    dcheck("reset_valid", int'(bus.DataOutValid), 0);
    dcheck("reset_fe", int'(bus.FramingError), 0);
    dcheck("reset_ovr", int'(bus.Overrun), 0);
    rst = 1'b0;
    idle(20);

    // Byte held for a long time, then released by a single ready cycle.
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    idle(1000);
    dcheck("hold_valid", int'(bus.DataOutValid), 1);
    dcheck("hold_data", int'(bus.DataOut), 8'hA5);
    drain();
    dcheck("released_valid", int'(bus.DataOutValid), 0);
    idle(20);

    // False start: short low pulse must be ignored.
    sin = 1'b0;
    repeat (30) step();
    idle(300);
    dcheck("false_start_valid", int'(bus.DataOutValid), 0);
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    idle(10);
    drain();
    idle(10);

    // Bad stop bit, then a good frame.
    send_frame(8'h55, 1'b0, 1'b0, -1);
    idle(10);
    dcheck("framing_valid", int'(bus.DataOutValid), 0);
    send_frame(8'h0F, 1'b1, 1'b0, -1);
    idle(10);
    drain();
    idle(10);

    // Back-to-back frames with no consumer: second byte overruns.
    send_frame(8'h11, 1'b1, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b0, -1);
    idle(10);
    dcheck("overrun_keeps_first", int'(bus.DataOut), 8'h11);
    drain();
    idle(10);
    // Same pair, consumer ready across the second frame: no overrun.
    send_frame(8'h11, 1'b1, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b1, -1);
    idle(10);
    dcheck("ready_second_data", int'(bus.DataOut), 8'h22);
    idle(10);

    // Reset in the middle of a frame while a byte is buffered.
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    idle(10);
    ff_bits = {1'b1, 8'hFF, 1'b0};
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < BitCycles; c++) begin
        if (i == 4 && c == 80) break;
        sin = ff_bits[i];
        step();
      end
    end
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    buf_full = 1'b0;
    dcheck("midreset_dataout", int'(bus.DataOut), 0);
    dcheck("midreset_valid", int'(bus.DataOutValid), 0);
    dcheck("midreset_fe", int'(bus.FramingError), 0);
    dcheck("midreset_ovr", int'(bus.Overrun), 0);
    idle(400);
    dcheck("midreset_no_output", int'(bus.DataOutValid), 0);
    send_frame(8'h81, 1'b1, 1'b0, -1);
    idle(10);
    drain();
    idle(10);

    // One inverted sample in the middle of data bit 3 is outvoted.
    send_frame(8'h00, 1'b1, 1'b0, 4);
    idle(10);
    drain();
    idle(10);

    // Random traffic.
    for (int n = 0; n < 16; n++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 4) != 0);
      rr = ($urandom_range(0, 2) == 0);
      send_frame(rb, rs, rr, -1);
      idle($urandom_range(4, 60));
      if ($urandom_range(0, 1) == 1) begin
        drain();
        idle(4);
      end
    end

    idle(300);
    dcheck("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", dir_pass + mon_pass, dir_total + mon_total);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 SHALL have parameter ClockFreq, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BaudRate, default 115_200, serial bit rate.
REQ-003 SHALL have parameter Oversample, default 16, sample ticks per bit.
REQ-004 SHALL have port Clock  input  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port SIn  input  1  asynchronous serial line; idle high.
REQ-007 SHALL have port DataOut  output  8  received byte.
REQ-008 SHALL have port DataOutValid  output  1  DataOut holds an unconsumed byte.
REQ-009 SHALL have port DataOutReady  input  1  consumer accepts DataOut.
REQ-010 SHALL have port FramingError  output  1  one-cycle pulse, bad stop bit.
REQ-011 SHALL have port Overrun  output  1  one-cycle pulse, good byte dropped.

Function
REQ-012 SHALL pass SIn through a 2-flop synchronizer; all logic uses the synchronized value.
REQ-013 SHALL generate a sample tick every TickTime = ClockFreq/(BaudRate*Oversample) cycles (integer division); the tick counter is cleared on start-edge detection.
REQ-014 SHALL count ticks within a bit in a sub-counter 0..Oversample-1, wrapping to 0 and advancing the bit position.
REQ-015 SHALL implement states IDLE, START, DATA, STOP.
REQ-016 IDLE: falling edge of synchronized SIn (previous 1, current 0) -> START, tick and sub-counters cleared.
REQ-017 Each bit value SHALL be the majority of samples taken at sub-counts Oversample/2-1, Oversample/2, Oversample/2+1.
REQ-018 START: majority 1 at sub-count Oversample/2+1 -> IDLE (false start, nothing reported); majority 0 -> DATA at the end of the bit.
REQ-019 DATA: 8 bits, LSB first, shifted into an internal register; after bit 7 ends -> STOP.
REQ-020 STOP: decision at sub-count Oversample/2+1, then -> IDLE immediately (no wait for end of stop bit).
REQ-021 Stop majority 1: byte is good; stop majority 0: FramingError = 1 for exactly one cycle, byte discarded, DataOut/DataOutValid unchanged.
REQ-022 Good byte with DataOutValid = 0, or with DataOutValid = 1 and DataOutReady = 1 in the same cycle: DataOut loaded, DataOutValid = 1 on the next cycle.
REQ-023 Good byte with DataOutValid = 1 and DataOutReady = 0: new byte dropped, DataOut held, Overrun = 1 for exactly one cycle.
REQ-024 DataOutValid SHALL stay 1 and DataOut stable until a cycle with DataOutReady = 1; it clears on the following edge unless REQ-022 reloads it.
REQ-025 DataOutReady while DataOutValid = 0 SHALL have no effect.
REQ-026 FramingError and Overrun SHALL never assert in the same cycle as each other.

Reset
REQ-027 Reset SHALL force: state IDLE, counters 0, synchronizer flops and edge-detect register 1, shift register 0, DataOut 0x00, DataOutValid 0, FramingError 0, Overrun 0.
REQ-028 Reset mid-frame SHALL abandon the frame with no outputs; the next falling edge after Reset deasserts starts a new frame.

Verification (ClockFreq=1_600_000, BaudRate=10_000, Oversample=16 -> 10 cycles/tick, 160 cycles/bit)
REQ-029 Frame 0xA5, stop 1, Ready=0 -> DataOutValid=1, DataOut=0xA5, held 1000 cycles; Ready=1 one cycle -> DataOutValid=0 next cycle.
REQ-030 SIn low for 30 cycles then high -> no DataOutValid and no FramingError; following frame 0x3C received as 0x3C.
REQ-031 Frame 0x55 with stop bit 0 -> FramingError one-cycle pulse, DataOutValid stays 0; next frame 0x0F received correctly.
REQ-032 Back-to-back 0x11, 0x22, Ready=0 -> DataOut=0x11 after both frames, Overrun single pulse at 0x22 stop decision; Ready pulsed at 0x22 completion instead -> DataOut=0x22, no Overrun.
REQ-033 Reset during bit 4 of 0xFF -> all outputs 0 and state IDLE; subsequent 0x81 received as 0x81.
REQ-034 Frame 0x00 with SIn inverted for one tick at sub-count 8 of bit 3 -> received 0x00 (majority vote).
